conf_int_mac_pipe_truncated: RTL and testbench
==============================================

Name: conf_int_mac_pipe_truncated

Overview:
- Pipelined, parametrised truncated-operand integer MAC for the approximate-computing datapath library.
- Zeroes a per-beat, runtime-selectable number of LSBs (nab) of both multiplicands, multiplies, then adds either the addend c (single mode) or a running per-frame accumulator (accumulate mode).
- Valid/ready handshake on both sides; optional saturation with an overflow flag.
- Sits between operand FIFOs and the result writeback in the conf-int kernels.

Parameters:
- DATA_PATH_BITWIDTH, 16, width of a, b, c (unsigned).
- ACC_BITWIDTH, 40, width of accumulator and d; must be >= 2*DATA_PATH_BITWIDTH.
- NAB_W, 5, width of nab port; must satisfy 2^NAB_W > DATA_PATH_BITWIDTH.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_BITWIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a rising clk edge resets).
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- a  input  DATA_PATH_BITWIDTH  multiplicand.
- b  input  DATA_PATH_BITWIDTH  multiplier.
- c  input  DATA_PATH_BITWIDTH  addend / frame seed (never truncated).
- nab  input  NAB_W  number of truncated LSBs of a and b, sampled with the beat.
- acc_mode  input  1  0 = single MAC, 1 = accumulate; sampled per beat.
- last  input  1  final beat of an accumulate frame.
- out_valid  output  1  d valid.
- out_ready  input  1  downstream accepts d.
- d  output  ACC_BITWIDTH  result.
- out_last  output  1  last flag of the beat carried by d.
- overflow  output  1  overflow status of the beat carried by d.

Behaviour:
- Unsigned arithmetic throughout.
- Truncation:
  - a_t = a with bits [nab-1:0] forced to 0; b_t likewise.
  - nab >= DATA_PATH_BITWIDTH forces a_t = b_t = 0.
  - nab = 0 gives an exact multiply.
- Product p = a_t*b_t, 2*DATA_PATH_BITWIDTH bits, zero-extended to ACC_BITWIDTH.
- Pipeline, 3 register stages, latency 3 cycles from accepted beat to out_valid with no stall:
  - S1 registers a_t, b_t, c, acc_mode, last.
  - S2 registers p and the sideband.
  - S3 computes and registers d, out_last, overflow.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - Global advance adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv = 0, all stages and outputs hold; no beat is lost or duplicated.
  - Bubbles travel as cleared stage-valid bits.
  - An output transfer occurs when out_valid && out_ready.
- Accumulation, evaluated in S3 when a valid beat advances into it:
  - acc_mode=0: sum = p + c. Does not touch the accumulator or the first-beat flag.
  - acc_mode=1, first beat of frame: sum = c + p.
  - acc_mode=1, other beats: sum = acc + p; c is ignored.
  - acc_mode=1: acc <= result.
  - "First beat of frame" means first beat after reset or after a beat with last=1 and acc_mode=1.
  - last is ignored when acc_mode=0.
- Overflow:
  - sum is computed at ACC_BITWIDTH+1 bits; carry out means overflow.
  - SATURATE=1: d = all ones. SATURATE=0: d = low ACC_BITWIDTH bits.
  - acc_mode=1: overflow is sticky for the rest of the frame and clears on the next frame's first beat.
  - acc_mode=0: overflow is per beat only.
- Reset:
  - All stage valids, out_valid, d, out_last, overflow and acc go to 0; the first-beat flag is set.
  - Reset mid-frame discards all in-flight beats and the partial sum.
  - in_ready = 1 in the first cycle after reset.
- Mixing acc_mode within a frame is allowed: single-mode beats pass through, and the frame resumes on the next acc_mode=1 beat.

Test Plan:
- Default params; nab=12, acc_mode=0, a=0xF123, b=0x2FFF, c=0x0005 -> d=0x001E000005 three cycles after acceptance, overflow=0.
- nab=0, acc_mode=0, a=3, b=4, c=5 -> d=17. Then nab=16, a=b=0xFFFF, c=9 -> d=9.
- nab=0, acc_mode=1, back-to-back beats (2,3,c=10), (4,5,c=99), (1,1,c=7,last=1) -> d=16, 36, 37 with out_last on the third. Next beat (1,1,c=0,last=1) -> d=1.
- ACC_BITWIDTH=32, SATURATE=1, nab=0, acc_mode=1, a=b=0xFFFF, c=0, two beats -> d=0xFFFE0001 with overflow=0, then d=0xFFFFFFFF with overflow=1. Repeat with SATURATE=0 -> second d=0xFFFC0002, overflow=1.
- Stream 6 beats with out_ready held 0 for 5 cycles mid-stream:
  - in_ready drops in the same cycle out_valid=1 and out_ready=0.
  - d is stable while stalled.
  - All 6 results emerge in order with correct values.
- Accumulate frame of 2 beats (sum 16), then rst=0 for one cycle with beats in flight -> out_valid=0, d=0. Next beat (1,1,c=7,acc_mode=1) -> d=8, i.e. treated as first beat.

Source files
------------

// File: rtl/conf_int_mac_pipe_truncated.sv
// Truncated-operand unsigned MAC: zero nab LSBs of a/b, multiply, add c or a per-frame accumulator.
// Three register stages; one global advance stalls the whole pipe when the output is held.
module conf_int_mac_pipe_truncated #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ACC_BITWIDTH       = 40,
  parameter int NAB_W              = 5,
  parameter bit SATURATE           = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  input  logic [DATA_PATH_BITWIDTH-1:0] c,
  input  logic [NAB_W-1:0]              nab,
  input  logic                          acc_mode,
  input  logic                          last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_BITWIDTH-1:0]       d,
  output logic                          out_last,
  output logic                          overflow
);

  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int AW = ACC_BITWIDTH;
  localparam int PW = 2 * DATA_PATH_BITWIDTH;
  localparam logic [NAB_W:0] DW_LIM = (NAB_W + 1)'(DW);

  logic adv;

  logic [DW-1:0] mask;
  logic [DW-1:0] a_t;
  logic [DW-1:0] b_t;

  logic          s1_vld;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic [DW-1:0] s1_c;
  logic          s1_mode;
  logic          s1_last;

  logic          s2_vld;
  logic [PW-1:0] s2_p;
  logic [DW-1:0] s2_c;
  logic          s2_mode;
  logic          s2_last;

  logic [AW-1:0] acc;
  logic          first;
  logic          sticky;

  logic [AW-1:0] addend;
  logic [AW:0]   sum;
  logic [AW-1:0] res;
  logic          carry;
  logic          ovf_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // nab at or beyond the operand width wipes both operands entirely
  always_comb begin
    mask = '0;
    if ({1'b0, nab} < DW_LIM) mask = {DW{1'b1}} << nab;
  end

  assign a_t = a & mask;
  assign b_t = b & mask;

  // Frame seed is c on the first accumulate beat; single-mode beats always add c
  always_comb begin
    addend = acc;
    if (!s2_mode || first) addend = AW'(s2_c);
    sum     = {1'b0, addend} + {1'b0, AW'(s2_p)};
    carry   = sum[AW];
    res     = sum[AW-1:0];
    if (carry && SATURATE) res = '1;
    ovf_nxt = carry || (s2_mode && !first && sticky);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld    <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_c      <= '0;
      s1_mode   <= 1'b0;
      s1_last   <= 1'b0;
      s2_vld    <= 1'b0;
      s2_p      <= '0;
      s2_c      <= '0;
      s2_mode   <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      d         <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      acc       <= '0;
      first     <= 1'b1;
      sticky    <= 1'b0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_a    <= a_t;
      s1_b    <= b_t;
      s1_c    <= c;
      s1_mode <= acc_mode;
      s1_last <= last;

      s2_vld  <= s1_vld;
      s2_p    <= {{DW{1'b0}}, s1_a} * {{DW{1'b0}}, s1_b};
      s2_c    <= s1_c;
      s2_mode <= s1_mode;
      s2_last <= s1_last;

      out_valid <= s2_vld;
      if (s2_vld) begin
        d        <= res;
        out_last <= s2_last;
        overflow <= ovf_nxt;
        if (s2_mode) begin
          acc    <= res;
          sticky <= ovf_nxt;
          first  <= s2_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_conf_int_mac_pipe_truncated.sv
// Directed bench: default instance plus two 32-bit accumulator instances (saturating and wrapping)
// driven from the same stimulus so overflow behaviour can be compared side by side.
module tb_conf_int_mac_pipe_truncated;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b, c;
  logic [4:0]  nab;
  logic        acc_mode;
  logic        last;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        ol0, ol1, ol2;
  logic        of0, of1, of2;
  logic [39:0] d0;
  logic [31:0] d1, d2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conf_int_mac_pipe_truncated u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .c(c), .nab(nab), .acc_mode(acc_mode), .last(last),
    .out_valid(ov0), .out_ready(out_ready), .d(d0), .out_last(ol0), .overflow(of0)
  );

  conf_int_mac_pipe_truncated #(.ACC_BITWIDTH(32), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .c(c), .nab(nab), .acc_mode(acc_mode), .last(last),
    .out_valid(ov1), .out_ready(out_ready), .d(d1), .out_last(ol1), .overflow(of1)
  );

  conf_int_mac_pipe_truncated #(.ACC_BITWIDTH(32), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a), .b(b), .c(c), .nab(nab), .acc_mode(acc_mode), .last(last),
    .out_valid(ov2), .out_ready(out_ready), .d(d2), .out_last(ol2), .overflow(of2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] tc,
                      input logic [4:0] tn, input logic tm, input logic tl);
    a = ta; b = tb; c = tc; nab = tn; acc_mode = tm; last = tl;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ov0 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, 64'(ov0), 64'd1);
  endtask

  function automatic logic [39:0] stream_exp(input int k);
    return 40'((k + 1) * (k + 2) + k);
  endfunction

  initial begin
    int          sent;
    int          recv;
    logic        acc_in;
    logic        was_stall;
    logic [39:0] held;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; nab = '0; acc_mode = 1'b0; last = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_vld",  64'(ov0), 64'd0);
    chk("rst_d",    64'(d0),  64'd0);
    chk("rst_ovf",  64'(of0), 64'd0);
    chk("rst_last", 64'(ol0), 64'd0);
    chk("rst_rdy",  64'(ir0), 64'd1);

    // exact latency and truncation at nab=12
    send(16'hF123, 16'h2FFF, 16'h0005, 5'd12, 1'b0, 1'b0);
    chk("lat_c1", 64'(ov0), 64'd0);
    step();
    chk("lat_c2", 64'(ov0), 64'd0);
    step();
    chk("lat_c3", 64'(ov0), 64'd1);
    chk("t1_d",   64'(d0),  64'h001E000005);
    chk("t1_ovf", 64'(of0), 64'd0);
    step();

    send(16'd3, 16'd4, 16'd5, 5'd0, 1'b0, 1'b0);
    wait_valid("exact");
    chk("exact_d", 64'(d0), 64'd17);
    step();
    send(16'hFFFF, 16'hFFFF, 16'd9, 5'd16, 1'b0, 1'b0);
    wait_valid("nab16");
    chk("nab16_d", 64'(d0), 64'd9);
    step();
    send(16'hFFFF, 16'hFFFF, 16'd1, 5'd15, 1'b0, 1'b0);
    wait_valid("nab15");
    chk("nab15_d", 64'(d0), 64'h40000001);
    step();

    // accumulate frame, back to back
    send(16'd2, 16'd3, 16'd10, 5'd0, 1'b1, 1'b0);
    send(16'd4, 16'd5, 16'd99, 5'd0, 1'b1, 1'b0);
    send(16'd1, 16'd1, 16'd7,  5'd0, 1'b1, 1'b1);
    wait_valid("acc1");
    chk("acc1_d", 64'(d0), 64'd16);
    chk("acc1_last", 64'(ol0), 64'd0);
    step();
    wait_valid("acc2");
    chk("acc2_d", 64'(d0), 64'd36);
    step();
    wait_valid("acc3");
    chk("acc3_d", 64'(d0), 64'd37);
    chk("acc3_last", 64'(ol0), 64'd1);
    step();
    send(16'd1, 16'd1, 16'd0, 5'd0, 1'b1, 1'b1);
    wait_valid("acc4");
    chk("acc4_d", 64'(d0), 64'd1);
    step();

    // overflow, saturate vs wrap, sticky within frame
    send(16'hFFFF, 16'hFFFF, 16'd0, 5'd0, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 16'd0, 5'd0, 1'b1, 1'b0);
    send(16'd0,    16'd0,    16'd5, 5'd0, 1'b1, 1'b1);
    wait_valid("ov1");
    chk("ov1_sat_d",   64'(d1),  64'hFFFE0001);
    chk("ov1_sat_f",   64'(of1), 64'd0);
    chk("ov1_wrap_d",  64'(d2),  64'hFFFE0001);
    step();
    wait_valid("ov2");
    chk("ov2_sat_d",   64'(d1),  64'hFFFFFFFF);
    chk("ov2_sat_f",   64'(of1), 64'd1);
    chk("ov2_wrap_d",  64'(d2),  64'hFFFC0002);
    chk("ov2_wrap_f",  64'(of2), 64'd1);
    chk("ov2_wide_d",  64'(d0),  64'h1FFFC0002);
    chk("ov2_wide_f",  64'(of0), 64'd0);
    step();
    wait_valid("ov3");
    chk("ov3_sat_d",   64'(d1),  64'hFFFFFFFF);
    chk("ov3_sticky1", 64'(of1), 64'd1);
    chk("ov3_wrap_d",  64'(d2),  64'hFFFC0002);
    chk("ov3_sticky2", 64'(of2), 64'd1);
    step();
    send(16'd0, 16'd0, 16'd3, 5'd0, 1'b1, 1'b1);
    wait_valid("ov4");
    chk("ov4_d",   64'(d2),  64'd3);
    chk("ov4_clr", 64'(of2), 64'd0);
    chk("ov4_clr1", 64'(of1), 64'd0);
    step();

    // streaming with a five-cycle output stall
    sent = 0;
    recv = 0;
    was_stall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 6) begin
        in_valid = 1'b1;
        a = 16'(sent + 1); b = 16'(sent + 2); c = 16'(sent);
        nab = '0; acc_mode = 1'b0; last = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (ov0 && !out_ready) chk("stall_rdy", 64'(ir0), 64'd0);
      if (was_stall) chk("stall_hold", 64'(d0), 64'(held));
      was_stall = ov0 && !out_ready;
      held = d0;
      if (ov0 && out_ready) begin
        chk($sformatf("stream_d%0d", recv), 64'(d0), 64'(stream_exp(recv)));
        recv++;
      end
      acc_in = in_valid && ir0;
      step();
      if (acc_in) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(recv), 64'd6);
    step();

    // reset with a partial frame in flight
    send(16'd2, 16'd3, 16'd4, 5'd0, 1'b1, 1'b0);
    send(16'd2, 16'd3, 16'd0, 5'd0, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_vld", 64'(ov0), 64'd0);
    chk("mrst_d",   64'(d0),  64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_quiet%0d", i), 64'(ov0), 64'd0);
    end
    send(16'd1, 16'd1, 16'd7, 5'd0, 1'b1, 1'b1);
    wait_valid("mrst_new");
    chk("mrst_new_d", 64'(d0), 64'd8);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
